// File: rtl/axis_out_ctrl_if.sv
// axis_out_ctrl_if: AXI-Stream beat channel between the result transmitter and its sink.
interface axis_out_ctrl_if #(parameter int CHAR_LEN = 8);
  logic [CHAR_LEN-1:0] tdata;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_out_ctrl.sv
// axis_out_ctrl: two-slot packet buffer serialising N-character result words onto AXI-Stream.
module axis_out_ctrl #(
  parameter int CHAR_LEN = 8,
  parameter int N = 10,
  parameter int CNT_W = 16
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic soft_clr,
  input  logic [N*CHAR_LEN-1:0] d,
  input  logic d_valid,
  output logic d_ready,
  axis_out_ctrl_if.master m_axis,
  output logic pkt_done,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic busy
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;
  logic [N*CHAR_LEN-1:0] slot [2];
  logic [1:0] cnt, cnt_n;
  logic wp, rp;
  logic [IW-1:0] idx;
  logic push, beat, last;
  assign d_ready = (cnt < 2'd2) && !soft_clr;
  assign busy = cnt != 2'd0;
  assign m_axis.tvalid = state == STREAM;
  assign m_axis.tlast = m_axis.tvalid && (idx == IW'(N-1));
  assign m_axis.tdata = slot[rp][32'(idx)*CHAR_LEN +: CHAR_LEN];
  // State follows the post-edge slot count so a word accepted at edge k is presented in cycle k+1.
  always_comb begin
    push = d_valid && d_ready;
    beat = m_axis.tvalid && m_axis.tready;
    last = beat && (idx == IW'(N-1));
    cnt_n = cnt + {1'b0, push} - {1'b0, last};
    state_n = (state == IDLE) ? ((cnt_n != 2'd0) ? STREAM : IDLE)
                              : ((last && cnt_n == 2'd0) ? IDLE : STREAM);
    if (soft_clr) state_n = IDLE;
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      idx <= '0;
      pkt_cnt <= '0;
      pkt_done <= 1'b0;
      slot[0] <= '0;
      slot[1] <= '0;
    end else if (soft_clr) begin
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      idx <= '0;
      pkt_cnt <= '0;
      pkt_done <= 1'b0;
    end else begin
      cnt <= cnt_n;
      pkt_done <= last;
      if (push) begin
        slot[wp] <= d;
        wp <= ~wp;
      end
      if (beat) idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        rp <= ~rp;
        pkt_cnt <= pkt_cnt + 1'b1;
      end
    end
endmodule

// File: doc/axis_out_ctrl.md
Name: axis_out_ctrl

Overview:
- AXI-Stream master transmitter for the accelerator result path; the output end of the stream that host-side software and benches consume.
- Accepts one parallel result word of N characters from the main controller, then serialises it onto M_AXIS one character per beat.
- TLAST is asserted on the Nth character of every packet.
- A two-slot packet buffer lets the main controller hand over the next batch item while the current one is still draining.

Parameters:
- CHAR_LEN, 8, bits per character (one beat of TDATA).
- N, 10, characters per packet.
- CNT_W, 16, width of the sent-packet counter.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous clear, driven from the slv_reg0 rst_n bit (inverted).
- d  in  N*CHAR_LEN  packet word; character j at bits [j*CHAR_LEN +: CHAR_LEN].
- d_valid  in  1  d is valid.
- d_ready  out  1  buffer slot free.
- M_AXIS_TDATA  out  CHAR_LEN  current character.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TLAST  out  1  last beat of packet.
- M_AXIS_TREADY  in  1  sink ready.
- pkt_done  out  1  one-cycle pulse after the final beat of a packet is accepted.
- pkt_cnt  out  CNT_W  packets fully sent since reset or clear.
- busy  out  1  high whenever any packet is buffered or streaming.

Behaviour:
- Reset (ARESETN=0, async): all outputs are 0 except d_ready, which is 1.
  - Slot count cnt=0, write pointer wp=0, read pointer rp=0, char index idx=0.
  - State = IDLE.
- State machine:
  - IDLE: TVALID=0. Go to STREAM when cnt becomes nonzero.
  - STREAM: TVALID=1. Go to IDLE when the last beat is accepted and cnt becomes 0.
- Input side:
  - d_ready = (cnt<2) && !soft_clr.
  - On d_valid && d_ready: slot[wp] <= d, wp toggles, cnt increments.
  - Latency: d accepted at edge k, so TVALID=1 and TDATA=char 0 from cycle k+1 onward when the buffer was empty.
- Output side:
  - TDATA = slot[rp][idx*CHAR_LEN +: CHAR_LEN]. Character 0 goes first (LSB-first order).
  - TLAST = TVALID && (idx==N-1).
  - On TVALID && TREADY: idx increments. If idx==N-1, then idx <= 0, rp toggles, cnt decrements, pkt_done=1 the next cycle, and pkt_cnt increments.
- Handshake rules:
  - While TVALID && !TREADY, TDATA, TLAST and idx hold.
  - TVALID never drops mid-packet except on soft_clr.
- Back-to-back packets: if cnt>1 at the last beat, char 0 of the next slot is presented the very next cycle with TVALID held high. No bubble.
- Simultaneous accept and last-beat pop in the same cycle: cnt is unchanged, both pointers toggle.
- Full (cnt=2): d_ready=0. A d_valid held high is not accepted, and d is ignored.
- Empty: TVALID=0; TDATA is don't-care (bench must not check it).
- pkt_cnt wraps 2^CNT_W-1 -> 0.
- busy = (cnt!=0).
- soft_clr=1 takes effect at the next edge and overrides all other events in that cycle, including a concurrent d accept or beat.
  - Clears cnt, wp, rp, idx, pkt_cnt, pkt_done; state returns to IDLE.
  - TVALID=0 from the following cycle.
  - A packet cleared mid-stream is truncated with no TLAST. The sink must also be reset.
- ARESETN asserted mid-packet: outputs drop immediately (asynchronously) to their reset values.

Test Plan:
- N=10, CHAR_LEN=8. Load d with chars 0x01..0x0A, TREADY=1 throughout -> 10 beats TDATA 0x01..0x0A on consecutive cycles, TLAST only on 0x0A, pkt_done one cycle later, pkt_cnt=1.
- Load two packets (0x11..0x1A, 0x21..0x2A) back-to-back, TREADY=1 -> 20 contiguous beats, TLAST on beats 10 and 20, no TVALID gap. Third d_valid while cnt=2 -> d_ready=0 and it is not accepted until the first TLAST handshake.
- TREADY toggled 1,0,0,1 pattern during a packet -> TDATA/TLAST stable while TREADY=0, all 10 chars delivered in order exactly once.
- Accept a new d in the same cycle as the last beat of the previous packet, with cnt=1 -> cnt stays 1, the next packet starts the next cycle with char 0.
- soft_clr pulsed at beat 4 of a packet -> TVALID=0 the next cycle, pkt_cnt=0, d_ready=1. A new packet then streams from char 0.
- ARESETN pulled low mid-packet -> TVALID/TLAST/pkt_done drop to 0 immediately, busy=0, d_ready=1.
